// File: rtl/rrat_commit.sv
// -----------------------------------------------------------------------------
// rrat_commit
//   Retirement RAT. Holds the committed arch->phys map, returns the displaced
//   physical register to the freelist on each commit, and publishes the
//   committed map with a one-cycle restore pulse after a flush.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   commit_valid    : ROB head retires this cycle
//   commit_rd       : architectural destination of retiring instruction
//   commit_pd       : physical destination of retiring instruction
//   flush_valid     : mispredict/flush (shared with freelist)
//   free_valid      : registered, displaced pd is being returned
//   free_pd         : registered, displaced pd
//   restore_valid   : registered one-cycle pulse, speculative RAT copies rrat_map
//   rrat_map        : combinational view of the table, entry i at [i*WIDTH +: WIDTH]
// -----------------------------------------------------------------------------
module rrat_commit #(
   parameter int LOG_REGS = 32,
   parameter int PHY_REGS = 64,
   parameter int WIDTH    = $clog2(PHY_REGS),
   parameter int AW       = $clog2(LOG_REGS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      commit_valid,
   input  logic [AW-1:0]             commit_rd,
   input  logic [WIDTH-1:0]          commit_pd,
   input  logic                      flush_valid,
   output logic                      free_valid,
   output logic [WIDTH-1:0]          free_pd,
   output logic                      restore_valid,
   output logic [LOG_REGS*WIDTH-1:0] rrat_map
);

   logic [WIDTH-1:0] r_table [LOG_REGS];

   logic             w_accept;
   logic [WIDTH-1:0] w_old;
   logic             w_free;

   // x0 commits are dropped entirely, so entry 0 keeps its reset value of 0
   // and p0 is never handed back to the freelist.
   assign w_accept = commit_valid && (commit_rd != '0);
   assign w_old    = r_table[commit_rd];

   // The freelist resets to full in the cycle after a flush; a free issued
   // in that cycle would insert a pd twice, so it is suppressed. The table
   // write itself still happens so the restored map includes the branch.
   assign w_free   = w_accept && (w_old != commit_pd) && !flush_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LOG_REGS; i++)
            r_table[i] <= WIDTH'(i);
      end else if (w_accept) begin
         r_table[commit_rd] <= commit_pd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         free_valid    <= 1'b0;
         free_pd       <= '0;
         restore_valid <= 1'b0;
      end else begin
         free_valid    <= w_free;
         restore_valid <= flush_valid;
         // free_pd is a don't-care while free_valid is low; hold it then.
         if (w_free)
            free_pd <= w_old;
      end
   end

   for (genvar g = 0; g < LOG_REGS; g++) begin : g_map
      assign rrat_map[g*WIDTH +: WIDTH] = r_table[g];
   end

endmodule

// File: tb/tb_rrat_commit.sv
// -----------------------------------------------------------------------------
// tb_rrat_commit
//   Directed self-checking bench for rrat_commit, followed by a short random
//   commit stream checked against a reference table.
// -----------------------------------------------------------------------------
module tb_rrat_commit;

   localparam int LOG_REGS = 32;
   localparam int WIDTH    = 6;
   localparam int AW       = 5;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      commit_valid;
   logic [AW-1:0]             commit_rd;
   logic [WIDTH-1:0]          commit_pd;
   logic                      flush_valid;
   logic                      free_valid;
   logic [WIDTH-1:0]          free_pd;
   logic                      restore_valid;
   logic [LOG_REGS*WIDTH-1:0] rrat_map;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] mtab [LOG_REGS];

   rrat_commit #(.LOG_REGS(LOG_REGS), .PHY_REGS(64), .WIDTH(WIDTH), .AW(AW)) dut (
      .clk           (clk),
      .rst           (rst),
      .commit_valid  (commit_valid),
      .commit_rd     (commit_rd),
      .commit_pd     (commit_pd),
      .flush_valid   (flush_valid),
      .free_valid    (free_valid),
      .free_pd       (free_pd),
      .restore_valid (restore_valid),
      .rrat_map      (rrat_map)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ent(input int i);
      return 32'(rrat_map[i*WIDTH +: WIDTH]);
   endfunction

   task automatic drive(input logic cv, input int rd, input int pd, input logic fl);
      commit_valid = cv;
      commit_rd    = AW'(rd);
      commit_pd    = WIDTH'(pd);
      flush_valid  = fl;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 0, 0, 1'b0);
      step();
      step();
      rst = 1'b0;

      // reset state
      for (int i = 0; i < LOG_REGS; i++)
         chk($sformatf("reset_map[%0d]", i), ent(i), i);
      chk("reset_free_valid", free_valid, 0);
      chk("reset_free_pd", free_pd, 0);
      chk("reset_restore", restore_valid, 0);

      // single commits to rd=5
      drive(1'b1, 5, 40, 1'b0); step();
      chk("c1_free_valid", free_valid, 1);
      chk("c1_free_pd", free_pd, 5);
      chk("c1_map5", ent(5), 40);
      drive(1'b1, 5, 41, 1'b0); step();
      chk("c2_free_valid", free_valid, 1);
      chk("c2_free_pd", free_pd, 40);
      chk("c2_map5", ent(5), 41);

      // x0 commit is ignored
      drive(1'b1, 0, 50, 1'b0); step();
      chk("x0_free_valid", free_valid, 0);
      chk("x0_map0", ent(0), 0);

      // idle
      drive(1'b0, 0, 0, 1'b0); step();
      chk("idle_free_valid", free_valid, 0);

      // back-to-back commits
      drive(1'b1, 3, 33, 1'b0); step();
      chk("b2b1_fv", free_valid, 1);
      chk("b2b1_pd", free_pd, 3);
      drive(1'b1, 3, 34, 1'b0); step();
      chk("b2b2_fv", free_valid, 1);
      chk("b2b2_pd", free_pd, 33);
      drive(1'b1, 7, 35, 1'b0); step();
      chk("b2b3_fv", free_valid, 1);
      chk("b2b3_pd", free_pd, 7);
      drive(1'b0, 0, 0, 1'b0); step();
      chk("b2b_end_fv", free_valid, 0);
      chk("b2b_map3", ent(3), 34);
      chk("b2b_map7", ent(7), 35);

      // degenerate commit: same pd already mapped, no free
      drive(1'b1, 7, 35, 1'b0); step();
      chk("same_pd_fv", free_valid, 0);
      chk("same_pd_map7", ent(7), 35);

      // flush with same-cycle commit
      drive(1'b1, 9, 60, 1'b1); step();
      chk("flush_restore", restore_valid, 1);
      chk("flush_map9", ent(9), 60);
      chk("flush_fv", free_valid, 0);
      drive(1'b0, 0, 0, 1'b0); step();
      chk("flush_restore_end", restore_valid, 0);
      chk("flush_fv_end", free_valid, 0);

      // consecutive flushes
      drive(1'b0, 0, 0, 1'b1); step();
      chk("ff1_restore", restore_valid, 1);
      step();
      chk("ff2_restore", restore_valid, 1);
      drive(1'b0, 0, 0, 1'b0); step();
      chk("ff_end_restore", restore_valid, 0);

      // reset mid-stream discards pending free and restores identity
      drive(1'b1, 12, 44, 1'b0); step();
      chk("pre_rst_fv", free_valid, 1);
      chk("pre_rst_pd", free_pd, 12);
      rst = 1'b1;
      drive(1'b1, 12, 45, 1'b1); step();
      chk("rst_fv", free_valid, 0);
      chk("rst_pd", free_pd, 0);
      chk("rst_restore", restore_valid, 0);
      chk("rst_map12", ent(12), 12);
      chk("rst_map5", ent(5), 5);
      rst = 1'b0;
      drive(1'b0, 0, 0, 1'b0); step();

      // random commit stream against a reference table
      for (int i = 0; i < LOG_REGS; i++)
         mtab[i] = WIDTH'(i);
      for (int n = 0; n < 300; n++) begin
         int  rd, pd;
         logic cv, fl, exp_fv;
         logic [WIDTH-1:0] exp_pd;
         cv = ($urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 15) == 0);
         rd = $urandom_range(0, LOG_REGS-1);
         pd = $urandom_range(0, 63);
         exp_fv = cv && (rd != 0) && (mtab[rd] != WIDTH'(pd)) && !fl;
         exp_pd = mtab[rd];
         if (cv && rd != 0)
            mtab[rd] = WIDTH'(pd);
         drive(cv, rd, pd, fl);
         step();
         chk("rnd_fv", free_valid, exp_fv);
         if (exp_fv)
            chk("rnd_pd", free_pd, exp_pd);
         chk("rnd_restore", restore_valid, fl);
         chk("rnd_map", ent(rd), mtab[rd]);
         chk("rnd_map0", ent(0), 0);
      end
      drive(1'b0, 0, 0, 1'b0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
